// File: rtl/mem_io_responder.sv
// mem_io_responder: wait-stated SRAM responder with one memory-mapped I/O word.
// Optional feature macro MEM_IO_HEX_EN: I/O-word writes load HEX_Data, not SRAM.
module mem_io_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        MEM_OE_n,
  input  logic        MEM_WE_n,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_Din,
  output logic [15:0] SRAM_Dout,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    HOLD
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        is_wr;
  logic [15:0] addr_q;
  logic        req, wr, io_hit;
  logic        load, done_rd;

  assign req = !MEM_OE_n || !MEM_WE_n;
  assign wr  = !MEM_WE_n;

`ifdef MEM_IO_HEX_EN
  assign io_hit = (ADDR == IO_ADDR);
`else
  // Without the hex register only reads are served from the I/O word
  assign io_hit = (ADDR == IO_ADDR) && !wr;
`endif

  assign SRAM_ADDR = {4'h0, addr_q};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    R         = 1'b0;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_Dout = '0;
    load      = 1'b0;
    done_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          load = 1'b1;
          if (io_hit) begin
            state_n = DONE;
          end else begin
            state_n = ACCESS;
            cnt_n   = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = is_wr;
        SRAM_WE_N = !is_wr;
        if (is_wr) SRAM_Dout = Data_from_CPU;
        if (cnt == 4'd0) begin
          state_n = DONE;
          done_rd = !is_wr;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        R       = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (!req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      is_wr       <= 1'b0;
      addr_q      <= '0;
      Data_to_CPU <= '0;
    end else begin
      if (load) begin
        is_wr  <= wr;
        addr_q <= ADDR;
      end
      if (load && io_hit && !wr) Data_to_CPU <= Switches;
      if (done_rd) Data_to_CPU <= SRAM_Din;
    end
  end

`ifdef MEM_IO_HEX_EN
  logic [15:0] hex_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_q <= '0;
    end else if (load && io_hit && wr) begin
      hex_q <= Data_from_CPU;
    end
  end

  assign HEX_Data = hex_q;
`else
  assign HEX_Data = '0;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: cycle table for SRAM/I-O accesses plus
// hand sequences for I/O write, held requests and mid-access reset.
module tb_mem_io_responder;

  logic        Clk;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        MEM_OE_n;
  logic        MEM_WE_n;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic        R;
  logic [15:0] HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_Din;
  logic [15:0] SRAM_Dout;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  int passed = 0;
  int total  = 0;

  mem_io_responder #(
    .WAIT_STATES(2),
    .IO_ADDR(16'hFFFF)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU),
    .MEM_OE_n(MEM_OE_n),
    .MEM_WE_n(MEM_WE_n),
    .Switches(Switches),
    .Data_to_CPU(Data_to_CPU),
    .R(R),
    .HEX_Data(HEX_Data),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_Din(SRAM_Din),
    .SRAM_Dout(SRAM_Dout),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        oe_n;
    logic        we_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] sw;
    logic [15:0] sdin;
    logic        r;
    logic        ce;
    logic        oe;
    logic        we;
    logic [19:0] saddr;
    logic [15:0] dout;
    logic [15:0] dtc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_OE_n = 1'b1;
    MEM_WE_n = 1'b1;
  endtask

  initial begin
    int rcount;
    int lat;
    bit got;

    vecs[0]  = '{1, 0, 16'h0030, 16'hBEEF, 16'h1234, 16'hBEEF,
                 0, 0, 1, 0, 20'h00030, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1, 0, 16'h0030, 16'hBEEF, 16'h1234, 16'hBEEF,
                 0, 0, 1, 0, 20'h00030, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1, 0, 16'h0030, 16'hBEEF, 16'h1234, 16'hBEEF,
                 1, 1, 1, 1, 20'h00030, 16'h0000, 16'h0000};
    vecs[3]  = '{1, 0, 16'h0030, 16'hBEEF, 16'h1234, 16'hBEEF,
                 0, 1, 1, 1, 20'h00030, 16'h0000, 16'h0000};
    vecs[4]  = '{1, 1, 16'h0030, 16'hBEEF, 16'h1234, 16'hBEEF,
                 0, 1, 1, 1, 20'h00030, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1, 16'h0030, 16'h0000, 16'h1234, 16'hBEEF,
                 0, 0, 0, 1, 20'h00030, 16'h0000, 16'h0000};
    vecs[6]  = '{0, 1, 16'h0030, 16'h0000, 16'h1234, 16'hBEEF,
                 0, 0, 0, 1, 20'h00030, 16'h0000, 16'h0000};
    vecs[7]  = '{0, 1, 16'h0030, 16'h0000, 16'h1234, 16'hBEEF,
                 1, 1, 1, 1, 20'h00030, 16'h0000, 16'hBEEF};
    vecs[8]  = '{0, 1, 16'h0030, 16'h0000, 16'h1234, 16'h1111,
                 0, 1, 1, 1, 20'h00030, 16'h0000, 16'hBEEF};
    vecs[9]  = '{1, 1, 16'h0030, 16'h0000, 16'h1234, 16'h1111,
                 0, 1, 1, 1, 20'h00030, 16'h0000, 16'hBEEF};
    vecs[10] = '{0, 1, 16'hFFFF, 16'h0000, 16'h1234, 16'h1111,
                 1, 1, 1, 1, 20'h0FFFF, 16'h0000, 16'h1234};
    vecs[11] = '{0, 1, 16'hFFFF, 16'h0000, 16'h1234, 16'h1111,
                 0, 1, 1, 1, 20'h0FFFF, 16'h0000, 16'h1234};
    vecs[12] = '{1, 1, 16'hFFFF, 16'h0000, 16'h1234, 16'h1111,
                 0, 1, 1, 1, 20'h0FFFF, 16'h0000, 16'h1234};

    Reset = 1'b0;
    ADDR = '0;
    Data_from_CPU = '0;
    Switches = 16'h1234;
    SRAM_Din = '0;
    idle_inputs();
    tick();
    tick();
    check("reset_state",
          {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR, SRAM_Dout,
           Data_to_CPU, HEX_Data},
          {1'b0, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0, 16'h0, 16'h0});
    Reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      MEM_OE_n      = vecs[i].oe_n;
      MEM_WE_n      = vecs[i].we_n;
      ADDR          = vecs[i].addr;
      Data_from_CPU = vecs[i].din;
      Switches      = vecs[i].sw;
      SRAM_Din      = vecs[i].sdin;
      tick();
      check($sformatf("vec%0d", i),
            {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR, SRAM_Dout,
             Data_to_CPU},
            {vecs[i].r, vecs[i].ce, vecs[i].oe, vecs[i].we, vecs[i].saddr,
             vecs[i].dout, vecs[i].dtc});
    end
    check("hex_after_table", {48'h0, HEX_Data}, 64'h0);

    ADDR = 16'hFFFF;
    Data_from_CPU = 16'h00A5;
    MEM_WE_n = 1'b0;
    tick();
`ifdef MEM_IO_HEX_EN
    check("io_wr_done",
          {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX_Data},
          {1'b1, 1'b1, 1'b1, 1'b1, 16'h00A5});
`else
    check("io_wr_acc1",
          {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR, SRAM_Dout},
          {1'b0, 1'b0, 1'b1, 1'b0, 20'h0FFFF, 16'h00A5});
    tick();
    check("io_wr_acc2",
          {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_ADDR, SRAM_Dout},
          {1'b0, 1'b0, 1'b1, 1'b0, 20'h0FFFF, 16'h00A5});
    tick();
    check("io_wr_done",
          {R, SRAM_CE_N, SRAM_WE_N, HEX_Data},
          {1'b1, 1'b1, 1'b1, 16'h0000});
`endif
    idle_inputs();
    tick();
    tick();
`ifdef MEM_IO_HEX_EN
    check("io_wr_hex_hold", {R, Data_to_CPU, HEX_Data},
          {1'b0, 16'h1234, 16'h00A5});
`else
    check("io_wr_hex_hold", {R, Data_to_CPU, HEX_Data},
          {1'b0, 16'h1234, 16'h0000});
`endif

    ADDR = 16'h0040;
    Data_from_CPU = 16'h5555;
    MEM_OE_n = 1'b0;
    MEM_WE_n = 1'b0;
    tick();
    check("both_low_is_write",
          {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_Dout},
          {1'b0, 1'b1, 1'b0, 16'h5555});
    rcount = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (R) rcount++;
    end
    check("held_single_pulse", rcount, 1);
    check("write_keeps_dtc", {48'h0, Data_to_CPU}, {48'h0, 16'h1234});
    idle_inputs();
    tick();
    tick();

    ADDR = 16'h0050;
    Data_from_CPU = 16'h7777;
    MEM_WE_n = 1'b0;
    tick();
    check("pre_reset_access", {SRAM_CE_N, SRAM_WE_N}, {1'b0, 1'b0});
    Reset = 1'b0;
    tick();
    check("reset_abort",
          {R, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_Dout, Data_to_CPU,
           HEX_Data},
          {1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0});
    Reset = 1'b1;
    idle_inputs();
    tick();

    ADDR = 16'h0030;
    SRAM_Din = 16'hCAFE;
    MEM_OE_n = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      tick();
      if (R) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("read_after_reset_r", {63'h0, got}, 64'h1);
    check("read_after_reset_lat", lat, 3);
    check("read_after_reset_data", {48'h0, Data_to_CPU}, {48'h0, 16'hCAFE});
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the LC-3 datapath's memory interface. It accepts read and write requests, runs a wait-stated access to the external SRAM, and returns read data with a one-cycle ready pulse. A single memory-mapped I/O word serves switch reads and hex-display writes. It sits between the CPU's MAR/MDR outputs and the board SRAM pins and replaces a purely combinational MEM2IO path.

## Interface
- WAIT_STATES, 2, number of cycles the SRAM strobes are held per access; legal range 1–15.
- IO_ADDR, 16'hFFFF, CPU address decoded as the I/O word.
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset; the block is in reset while Reset==0 at a rising edge of Clk.
- ADDR  in  16  CPU address (MAR).
- Data_from_CPU  in  16  write data (MDR).
- MEM_OE_n  in  1  active-low read request.
- MEM_WE_n  in  1  active-low write request.
- Switches  in  16  board switches; this value is returned on reads of IO_ADDR.
- Data_to_CPU  out  16  registered read data.
- R  out  1  ready; one-cycle pulse when an access completes.
- HEX_Data  out  16  hex-display register.
- SRAM_ADDR  out  20  SRAM address, formed as {4'h0, ADDR}.
- SRAM_Din  in  16  SRAM read data.
- SRAM_Dout  out  16  SRAM write data.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM strobes.

## Operation
- A request exists when MEM_OE_n==0 or MEM_WE_n==0.
- If both are low in the same cycle, the request is a write.
- The request type and address are captured in IDLE. ADDR, Data_from_CPU and the strobes must stay stable until R is seen.
- IDLE: R=0 and all SRAM strobes are high.
  - On a request to IO_ADDR, go to DONE with no SRAM access.
  - On any other request, go to ACCESS and load the wait counter with WAIT_STATES-1.
- ACCESS:
  - SRAM_CE_N=0 throughout.
  - For a read, SRAM_OE_N=0.
  - For a write, SRAM_WE_N=0 and SRAM_Dout=Data_from_CPU.
  - The wait counter decrements each cycle. When it reaches 0, a read latches SRAM_Din into Data_to_CPU and the FSM goes to DONE.
- DONE: R=1 for exactly one cycle and the strobes are released.
  - An I/O read latches Switches into Data_to_CPU on entry to DONE.
  - An I/O write latches Data_from_CPU into HEX_Data on entry to DONE.
  - Next state is HOLD.
- HOLD: waits until MEM_OE_n and MEM_WE_n are both high, then returns to IDLE. A request held across completion is not re-serviced.
- Data_to_CPU holds its value until the next read completes. Writes never change it.
- HEX_Data changes only on I/O writes.

## Timing
- Reset values: Data_to_CPU=0, HEX_Data=0, R=0, SRAM_CE_N/OE_N/WE_N=1, SRAM_Dout=0, state IDLE, wait counter 0.
- Reset asserted mid-access aborts the access. Strobes are high and R=0 at the first edge with Reset==0, and no partial write is reported.
- SRAM access latency:
  - The request is sampled at edge k.
  - Strobes are asserted in cycles k+1 through k+WAIT_STATES.
  - R=1 in cycle k+WAIT_STATES+1, with read data valid in the same cycle.
- I/O access latency: request at edge k gives R=1 in cycle k+1.
- Minimum request-to-request spacing: one cycle in HOLD with both request inputs high.
- SRAM_ADDR is driven from the captured address. It is stable for the whole ACCESS phase, including if ADDR changes illegally.

## Configuration
- MEM_IO_HEX_EN defined:
  - Writes to IO_ADDR update HEX_Data.
  - Writes to IO_ADDR never touch the SRAM.
- MEM_IO_HEX_EN undefined:
  - HEX_Data is tied to 0.
  - Writes to IO_ADDR are ordinary SRAM writes with full wait-state timing.
  - I/O reads still return Switches.

## Test plan
- Reset, then SRAM write 16'hBEEF to 16'h0030 with WAIT_STATES=2:
  - SRAM_WE_N and SRAM_CE_N are low for exactly 2 cycles with SRAM_ADDR=20'h00030 and SRAM_Dout=16'hBEEF.
  - R pulses once, in the 3rd cycle after the request.
- SRAM read of 16'h0030 with the model returning 16'hBEEF:
  - SRAM_OE_N is low for 2 cycles.
  - Data_to_CPU=16'hBEEF when R=1 and stays there through HOLD.
- Switches=16'h1234, read of 16'hFFFF:
  - No SRAM strobe goes low.
  - R=1 one cycle after the request, with Data_to_CPU=16'h1234.
- With MEM_IO_HEX_EN, write 16'h00A5 to 16'hFFFF:
  - HEX_Data=16'h00A5 and no SRAM strobes.
  - Without the macro: HEX_Data stays 0 and an SRAM write to 20'h0FFFF occurs.
- MEM_OE_n and MEM_WE_n both low:
  - The access is a write (SRAM_WE_N low, SRAM_OE_N high).
  - Holding the request low for 10 cycles after R produces only one R pulse.
- Reset driven to 0 during the first ACCESS cycle of a write:
  - Next cycle all strobes are 1, R=0, Data_to_CPU=0 and HEX_Data=0.
  - After release, a new read completes normally.
